// File: rtl/arith_pkg.sv
// ============================================================================
//  Module      : arith_pkg
//  Description : Shared operation/state encodings and divide-by-zero constant
//                for seq_arith_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arith_pkg;

    localparam int c_MAX_RES_W = 64;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DIV  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Exception value: only the MSB of a width-bit result is set.
    function automatic logic [c_MAX_RES_W-1:0] div_zero_value(input int width);
        div_zero_value            = '0;
        div_zero_value[width-1]   = 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
//  Module      : seq_divider
//  Description : Iterative restoring divider, one quotient bit per cycle,
//                MSB first. quotient/remainder present the final values in
//                the cycle where done is high.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int                 c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    logic               r_busy;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_div;

    logic [WIDTH:0]     w_partial;
    logic               w_fits;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;

    // Shift the next dividend bit into the partial remainder, subtract if it fits.
    assign w_partial  = {r_rem, r_quo[WIDTH-1]};
    assign w_fits     = (w_partial >= {1'b0, r_div});
    assign w_rem_next = w_fits ? WIDTH'(w_partial - {1'b0, r_div}) : w_partial[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_fits};

    assign busy      = r_busy;
    assign done      = r_busy && (r_cnt == c_LAST);
    assign quotient  = w_quo_next;
    assign remainder = w_rem_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_quo  <= dividend;
            r_rem  <= '0;
            r_div  <= divisor;
        end else if (r_busy) begin
            r_quo <= w_quo_next;
            r_rem <= w_rem_next;
            if (r_cnt == c_LAST) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_arith_unit.sv
// ============================================================================
//  Module      : seq_arith_unit
//  Description : Handshaked add/sub/mul/div unit with 2*WIDTH-bit result.
//                Define ARITH_DIV_EN to include the iterative divider;
//                otherwise every divide returns the exception value.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_arith_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               exception_flag
);

    localparam int                 c_RES_W    = 2 * WIDTH;
    localparam logic [c_RES_W-1:0] c_DIV_ZERO = c_RES_W'(div_zero_value(c_RES_W));

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [c_RES_W-1:0] r_result;
    logic               r_exc;

    logic               w_accept;
    logic               w_div_start;
    logic [c_RES_W-1:0] w_a_ext;
    logic [c_RES_W-1:0] w_b_ext;
    logic [c_RES_W-1:0] w_fast_result;
    logic               w_fast_exc;

    assign in_ready       = r_in_ready;
    assign out_valid      = r_out_valid;
    assign result         = r_result;
    assign exception_flag = r_exc;

    assign w_accept = in_valid && r_in_ready;
    assign w_a_ext  = {{WIDTH{1'b0}}, operand_a};
    assign w_b_ext  = {{WIDTH{1'b0}}, operand_b};

`ifdef ARITH_DIV_EN
    logic             w_div_busy;
    logic             w_div_done;
    logic [WIDTH-1:0] w_div_quo;
    logic [WIDTH-1:0] w_div_rem;

    assign w_div_start = w_accept && (op_t'(op) == OP_DIV) && (operand_b != '0);

    seq_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (w_div_start),
        .dividend  (operand_a),
        .divisor   (operand_b),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .quotient  (w_div_quo),
        .remainder (w_div_rem)
    );
`else
    assign w_div_start = 1'b0;
`endif

    // Single-cycle results, computed straight from the operands on the accept edge.
    always_comb begin
        w_fast_result = '0;
        w_fast_exc    = 1'b0;
        case (op_t'(op))
            OP_ADD: w_fast_result = w_a_ext + w_b_ext;
            OP_SUB: w_fast_result = w_a_ext - w_b_ext;
            OP_MUL: w_fast_result = w_a_ext * w_b_ext;
            OP_DIV: begin
                w_fast_result = c_DIV_ZERO;
                w_fast_exc    = 1'b1;
            end
            default: begin
                w_fast_result = '0;
                w_fast_exc    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_exc       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (w_div_start) begin
                            r_state <= DIV;
                        end else begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_fast_result;
                            r_exc       <= w_fast_exc;
                        end
                    end
                end
`ifdef ARITH_DIV_EN
                DIV: begin
                    if (w_div_busy && w_div_done) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= {w_div_rem, w_div_quo};
                        r_exc       <= 1'b0;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_arith_unit.sv
// ============================================================================
//  Module      : tb_seq_arith_unit
//  Description : Directed and randomized checks of seq_arith_unit against a
//                plain-arithmetic reference model (honours ARITH_DIV_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_arith_unit;

    localparam int W = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [W-1:0]    operand_a;
    logic [W-1:0]    operand_b;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  result;
    logic            exception_flag;

    int n_checks = 0;
    int n_pass   = 0;

    seq_arith_unit #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .op             (op),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result),
        .exception_flag (exception_flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Reference model straight from the arithmetic definition.
    task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [2*W-1:0] r, output logic f, output int lat);
        longint unsigned av = longint'(a);
        longint unsigned bv = longint'(b);
        longint unsigned m  = (64'd1 << (2*W)) - 1;
        f   = 1'b0;
        lat = 1;
        case (o)
            2'b00: r = (2*W)'((av + bv) & m);
            2'b01: r = (2*W)'((av - bv) & m);
            2'b10: r = (2*W)'((av * bv) & m);
            default: begin
                r = (2*W)'(64'd1 << (2*W - 1));
                f = 1'b1;
`ifdef ARITH_DIV_EN
                if (bv != 0) begin
                    r   = (2*W)'(((av % bv) << W) | (av / bv));
                    f   = 1'b0;
                    lat = 1 + W;
                end
`endif
            end
        endcase
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("in_ready_before_issue", in_ready, 1);
    endtask

    // Issue one operation, measure latency, then hold out_ready low for 'stall' cycles.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int stall);
        logic [2*W-1:0] er;
        logic           ef;
        int             elat;
        int             lat;
        logic           busy_ok;
        model(o, a, b, er, ef, elat);
        wait_ready();
        in_valid  = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        out_ready = (stall == 0);
        tick();
        in_valid = 1'b0;
        lat      = 1;
        busy_ok  = 1'b1;
        while (!out_valid && lat < 200) begin
            if (in_ready) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (in_ready) busy_ok = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(elat));
        check({tag, "_result"}, result, er);
        check({tag, "_flag"}, exception_flag, ef);
        check({tag, "_in_ready_low"}, busy_ok, 1);
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, "_stall_hold"}, {out_valid, in_ready, exception_flag, result},
                  {1'b1, 1'b0, ef, er});
        end
        out_ready = 1'b1;
        tick();
        check({tag, "_after_handshake"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        logic           stable;
        logic [2*W-1:0] er;
        logic           ef;
        int             elat;
        logic           stray;

        rst       = 1'b0;
        in_valid  = 1'b0;
        op        = 2'b00;
        operand_a = '0;
        operand_b = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_flag", exception_flag, 0);
        rst = 1'b1;
        tick();
        check("reset_in_ready", in_ready, 1);

        do_op("add", 2'b00, 16'h1234, 16'h0F0F, 0);
        do_op("sub", 2'b01, 16'd3, 16'd5, 0);
        do_op("mul", 2'b10, 16'hFFFF, 16'hFFFF, 0);
        do_op("div_100_7", 2'b11, 16'd100, 16'd7, 0);
        do_op("div_by_zero", 2'b11, 16'h1234, 16'h0000, 0);
        do_op("div_small", 2'b11, 16'd3, 16'd9, 0);
        do_op("div_max", 2'b11, 16'hFFFF, 16'h0001, 0);
        do_op("add_max", 2'b00, 16'hFFFF, 16'hFFFF, 0);
        do_op("sub_zero", 2'b01, 16'h0000, 16'h0001, 2);

        // Backpressure with a second request waiting on in_ready.
        out_ready = 1'b0;
        wait_ready();
        in_valid  = 1'b1;
        op        = 2'b00;
        operand_a = 16'h1234;
        operand_b = 16'h0F0F;
        tick();
        operand_a = 16'd5;
        operand_b = 16'd6;
        check("bp_first_result", {out_valid, result}, {1'b1, 32'h0000_2143});
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!(out_valid === 1'b1 && in_ready === 1'b0 && result === 32'h0000_2143 &&
                  exception_flag === 1'b0)) stable = 1'b0;
        end
        check("bp_hold_stable", stable, 1);
        out_ready = 1'b1;
        tick();
        check("bp_not_accepted_yet", {out_valid, in_ready}, 2'b01);
        tick();
        in_valid = 1'b0;
        check("bp_second_result", {out_valid, result}, {1'b1, 32'd11});
        tick();
        check("bp_second_done", {out_valid, in_ready}, 2'b01);

        // Reset in the middle of a divide (or in DONE without the divider).
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 2'b11;
        operand_a = 16'd100;
        operand_b = 16'd7;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b0;
        tick();
        check("abort_state", {out_valid, exception_flag, result}, 34'd0);
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        check("abort_in_ready", {out_valid, in_ready}, 2'b01);
        stray = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) stray = 1'b1;
        end
        check("abort_no_output", stray, 0);
        do_op("post_abort_add", 2'b00, 16'd1, 16'd1, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = W'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            do_op("rand", ro, ra, rb, int'($urandom_range(0, 2)));
        end

        model(2'b00, 16'd1, 16'd2, er, ef, elat);
        check("model_sanity_add", {ef, er}, {1'b0, 32'd3});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
